// File: rtl/pc_gen_if.sv
// Fetch-request channel between the program-counter generator and the IFU.
// The generator drives the address, its valid flag and the flush pulse;
// the IFU answers with ready.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            ifu_ready;
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic            flush;

    modport master (
        input  ifu_ready,
        output pc_valid,
        output pc,
        output flush
    );

    modport slave (
        output ifu_ready,
        input  pc_valid,
        input  pc,
        input  flush
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the NPC core.
// Holds the fetch address, steps it by 4 on each accepted fetch and applies
// prioritised redirects (trap > mret > jalr > jal > br). A misaligned
// jump/branch target parks the unit in FAULT until a trap redirect arrives.
// All outputs come straight from registers.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter int              IALIGN    = 32,
    parameter int              CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    pc_gen_if.master                ifu,
    input  logic        [XLEN-1:0]  src_pc,
    input  logic signed [XLEN-1:0]  imm,
    input  logic        [XLEN-1:0]  rs1,
    input  logic        [XLEN-1:0]  mtvec,
    input  logic        [XLEN-1:0]  mepc,
    input  logic                    trap_en,
    input  logic                    mret_en,
    input  logic                    jalr_en,
    input  logic                    jal_en,
    input  logic                    br_en,
    output logic                    misalign,
    output logic        [XLEN-1:0]  bad_addr,
    output logic        [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Base plus signed offset, wrapping modulo 2^XLEN.
    function automatic logic [XLEN-1:0] add_wrap(
        input logic        [XLEN-1:0] base,
        input logic signed [XLEN-1:0] off
    );
        return base + $unsigned(off);
    endfunction

    // jalr target: register plus offset with the low bit forced to zero.
    function automatic logic [XLEN-1:0] jalr_target(
        input logic        [XLEN-1:0] base,
        input logic signed [XLEN-1:0] off
    );
        return add_wrap(base, off) & ~XLEN'(1);
    endfunction

    // 16-bit alignment only cares about bit 0; 32-bit alignment about [1:0].
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        if (IALIGN == 16) begin
            return addr[0];
        end
        return |addr[1:0];
    endfunction

    // Registered state (stage p1) driving the outputs.
    state_t           state_p1;
    logic [XLEN-1:0]  pc_p1;
    logic             vld_p1;
    logic             flush_p1;
    logic             misalign_p1;
    logic [XLEN-1:0]  bad_addr_p1;
    logic [CNT_W-1:0] fetch_cnt_p1;

    // Combinational decode (stage p0).
    logic             redir_p0;
    logic             chk_p0;
    logic [XLEN-1:0]  tgt_p0;
    logic             fault_p0;

    // Next-state values computed from p0 decode and p1 state.
    state_t           state_nxt;
    logic [XLEN-1:0]  pc_nxt;
    logic             vld_nxt;
    logic             flush_nxt;
    logic             misalign_nxt;
    logic [XLEN-1:0]  bad_addr_nxt;
    logic [CNT_W-1:0] fetch_cnt_nxt;

    // ---- stage p0: pick the winning redirect and its target ----
    // Resolve redirect priority; only jump/branch targets get the alignment check.
    always_comb begin
        redir_p0 = 1'b1;
        chk_p0   = 1'b0;
        tgt_p0   = '0;
        if (trap_en) begin
            tgt_p0 = mtvec;
        end else if (mret_en) begin
            tgt_p0 = mepc;
        end else if (jalr_en) begin
            tgt_p0 = jalr_target(rs1, imm);
            chk_p0 = 1'b1;
        end else if (jal_en || br_en) begin
            tgt_p0 = add_wrap(src_pc, imm);
            chk_p0 = 1'b1;
        end else begin
            redir_p0 = 1'b0;
        end
    end

    // Flag a checked target that violates the instruction alignment.
    always_comb begin
        fault_p0 = chk_p0 && is_misaligned(tgt_p0);
    end

    // Next-state and next-output logic of the BOOT/RUN/FAULT controller.
    always_comb begin
        state_nxt     = state_p1;
        pc_nxt        = pc_p1;
        flush_nxt     = 1'b0;
        misalign_nxt  = 1'b0;
        bad_addr_nxt  = bad_addr_p1;
        fetch_cnt_nxt = fetch_cnt_p1;
        case (state_p1)
            ST_BOOT: begin
                // Redirects are not honoured before the first fetch is offered.
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redir_p0) begin
                    // A redirect squashes any fetch accepted in the same cycle.
                    if (fault_p0) begin
                        misalign_nxt = 1'b1;
                        bad_addr_nxt = tgt_p0;
                        state_nxt    = ST_FAULT;
                    end else begin
                        pc_nxt    = tgt_p0;
                        flush_nxt = 1'b1;
                    end
                end else if (ifu.ifu_ready) begin
                    pc_nxt        = pc_p1 + XLEN'(4);
                    fetch_cnt_nxt = fetch_cnt_p1 + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                // Parked: only the trap redirect gets the unit running again.
                if (trap_en) begin
                    pc_nxt    = mtvec;
                    flush_nxt = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
        vld_nxt = (state_nxt == ST_RUN);
    end

    // ---- stage p1: registered state and outputs ----
    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= ST_BOOT;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Fetch address, valid, pulses, fault address and fetch counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p1        <= RESET_VEC;
            vld_p1       <= 1'b0;
            flush_p1     <= 1'b0;
            misalign_p1  <= 1'b0;
            bad_addr_p1  <= '0;
            fetch_cnt_p1 <= '0;
        end else begin
            pc_p1        <= pc_nxt;
            vld_p1       <= vld_nxt;
            flush_p1     <= flush_nxt;
            misalign_p1  <= misalign_nxt;
            bad_addr_p1  <= bad_addr_nxt;
            fetch_cnt_p1 <= fetch_cnt_nxt;
        end
    end

    assign ifu.pc       = pc_p1;
    assign ifu.pc_valid = vld_p1;
    assign ifu.flush    = flush_p1;
    assign misalign     = misalign_p1;
    assign bad_addr     = bad_addr_p1;
    assign fetch_cnt    = fetch_cnt_p1;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (IALIGN=32/CNT_W=4 and IALIGN=16/CNT_W=8)
// share all inputs and are compared every cycle against a behavioural model,
// with directed scenarios followed by a randomized phase.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] src_pc, imm, rs1, mtvec, mepc;
    logic        trap_en, mret_en, jalr_en, jal_en, br_en;

    logic        mis_a, mis_b;
    logic [31:0] bad_a, bad_b;
    logic [3:0]  cnt_a;
    logic [7:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, index 0 = instance a, 1 = instance b.
    // mode: 0 booting, 1 running, 2 parked on a fault.
    logic [31:0] m_pc   [2];
    bit          m_vld  [2];
    bit          m_flush[2];
    bit          m_mis  [2];
    logic [31:0] m_bad  [2];
    int unsigned m_cnt  [2];
    int          m_mode [2];
    int unsigned al_bytes[2] = '{4, 2};
    int unsigned cnt_mod [2] = '{16, 256};

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) ifu_a ();
    pc_gen_if #(.XLEN(32)) ifu_b ();

    assign ifu_a.ifu_ready = ready;
    assign ifu_b.ifu_ready = ready;

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .IALIGN(32), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .ifu(ifu_a),
        .src_pc(src_pc), .imm(imm), .rs1(rs1), .mtvec(mtvec), .mepc(mepc),
        .trap_en(trap_en), .mret_en(mret_en), .jalr_en(jalr_en), .jal_en(jal_en), .br_en(br_en),
        .misalign(mis_a), .bad_addr(bad_a), .fetch_cnt(cnt_a)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .IALIGN(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .ifu(ifu_b),
        .src_pc(src_pc), .imm(imm), .rs1(rs1), .mtvec(mtvec), .mepc(mepc),
        .trap_en(trap_en), .mret_en(mret_en), .jalr_en(jalr_en), .jal_en(jal_en), .br_en(br_en),
        .misalign(mis_b), .bad_addr(bad_b), .fetch_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = RV; m_vld[i] = 0; m_flush[i] = 0; m_mis[i] = 0;
            m_bad[i] = '0; m_cnt[i] = 0; m_mode[i] = 0;
        end
    endtask

    // Apply the architectural rules for one rising edge.
    task automatic model_edge();
        logic [31:0] t;
        bit has, chk;
        for (int i = 0; i < 2; i++) begin
            m_flush[i] = 0;
            m_mis[i]   = 0;
            if (m_mode[i] == 0) begin
                m_mode[i] = 1;
            end else if (m_mode[i] == 2) begin
                if (trap_en) begin
                    m_pc[i] = mtvec; m_flush[i] = 1; m_mode[i] = 1;
                end
            end else begin
                has = 1; chk = 1; t = '0;
                if (trap_en)               begin t = mtvec; chk = 0; end
                else if (mret_en)          begin t = mepc;  chk = 0; end
                else if (jalr_en)          t = (rs1 + imm) & 32'hFFFF_FFFE;
                else if (jal_en || br_en)  t = src_pc + imm;
                else                       has = 0;
                if (has) begin
                    if (chk && (t % al_bytes[i]) != 0) begin
                        m_mis[i] = 1; m_bad[i] = t; m_mode[i] = 2;
                    end else begin
                        m_pc[i] = t; m_flush[i] = 1;
                    end
                end else if (ready) begin
                    m_pc[i]  = m_pc[i] + 32'd4;
                    m_cnt[i] = (m_cnt[i] + 1) % cnt_mod[i];
                end
            end
            m_vld[i] = (m_mode[i] == 1);
        end
    endtask

    task automatic check_all();
        check("a_pc",       ifu_a.pc,               m_pc[0]);
        check("a_pc_valid", {31'd0, ifu_a.pc_valid}, {31'd0, m_vld[0]});
        check("a_flush",    {31'd0, ifu_a.flush},    {31'd0, m_flush[0]});
        check("a_misalign", {31'd0, mis_a},          {31'd0, m_mis[0]});
        check("a_bad_addr", bad_a,                  m_bad[0]);
        check("a_fetch_cnt", {28'd0, cnt_a},        m_cnt[0]);
        check("b_pc",       ifu_b.pc,               m_pc[1]);
        check("b_pc_valid", {31'd0, ifu_b.pc_valid}, {31'd0, m_vld[1]});
        check("b_flush",    {31'd0, ifu_b.flush},    {31'd0, m_flush[1]});
        check("b_misalign", {31'd0, mis_b},          {31'd0, m_mis[1]});
        check("b_bad_addr", bad_b,                  m_bad[1]);
        check("b_fetch_cnt", {24'd0, cnt_b},        m_cnt[1]);
    endtask

    task automatic clear_in();
        trap_en = 0; mret_en = 0; jalr_en = 0; jal_en = 0; br_en = 0; ready = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 0;
        clear_in();
        src_pc = '0; imm = '0; rs1 = '0; mtvec = '0; mepc = '0;
        model_reset();

        // Reset state and boot
        #12;
        check_all();
        check("rst_pc", ifu_a.pc, RV);
        @(negedge clk);
        rst = 1;
        #1;
        check("boot_valid_low", {31'd0, ifu_a.pc_valid}, 32'd0);
        cycle();
        check("boot_valid_high", {31'd0, ifu_a.pc_valid}, 32'd1);
        check("boot_pc", ifu_a.pc, RV);

        // Streaming with back-pressure
        ready = 1;
        repeat (3) cycle();
        check("stream_pc3", ifu_a.pc, 32'h8000_000C);
        ready = 0;
        repeat (2) cycle();
        check("stall_pc", ifu_a.pc, 32'h8000_000C);
        ready = 1;
        cycle();
        check("stream_pc4", ifu_a.pc, 32'h8000_0010);
        check("stream_cnt", {28'd0, cnt_a}, 32'd4);

        // Priority: trap beats jal/br, and the concurrent fetch is squashed
        trap_en = 1; jal_en = 1; br_en = 1; mtvec = 32'h8000_0100;
        src_pc = 32'h8000_0000; imm = 32'd6;
        cycle();
        check("prio_pc", ifu_a.pc, 32'h8000_0100);
        check("prio_flush", {31'd0, ifu_a.flush}, 32'd1);
        check("squash_cnt", {28'd0, cnt_a}, 32'd4);
        clear_in();
        cycle();
        check("flush_drop", {31'd0, ifu_a.flush}, 32'd0);

        // jalr: aligned for IALIGN=16, misaligned for IALIGN=32
        jalr_en = 1; rs1 = 32'h8000_0203; imm = 32'd0;
        cycle();
        check("jalr16_pc", ifu_b.pc, 32'h8000_0202);
        check("jalr32_mis", {31'd0, mis_a}, 32'd1);
        check("jalr32_bad", bad_a, 32'h8000_0202);
        clear_in();
        cycle();
        check("mis_pulse", {31'd0, mis_a}, 32'd0);
        trap_en = 1; mtvec = RV;
        cycle();

        // Misaligned jal, ignored redirects while parked, trap recovery
        clear_in();
        jal_en = 1; src_pc = RV; imm = 32'd6;
        cycle();
        check("jal_mis", {31'd0, mis_a}, 32'd1);
        check("jal_bad", bad_a, 32'h8000_0006);
        check("jal_valid", {31'd0, ifu_a.pc_valid}, 32'd0);
        check("jal_pc_hold", ifu_a.pc, RV);
        clear_in();
        br_en = 1; mret_en = 1; mepc = 32'h8000_1234; ready = 1;
        cycle();
        check("fault_ignore_pc", ifu_a.pc, RV);
        clear_in();
        trap_en = 1; mtvec = 32'h8000_0040;
        cycle();
        check("trap_pc", ifu_a.pc, 32'h8000_0040);
        check("trap_flush", {31'd0, ifu_a.flush}, 32'd1);
        check("trap_valid", {31'd0, ifu_a.pc_valid}, 32'd1);

        // Counter wrap and address wrap
        clear_in();
        ready = 1;
        repeat (12) cycle();
        check("cnt_wrap_a", {28'd0, cnt_a}, 32'd0);
        check("cnt_b", {24'd0, cnt_b}, 32'd16);
        clear_in();
        jal_en = 1; src_pc = 32'hFFFF_FFFC; imm = 32'd8;
        cycle();
        check("addr_wrap", ifu_a.pc, 32'h0000_0004);

        // Asynchronous reset while parked
        clear_in();
        jal_en = 1; src_pc = 32'h0; imm = 32'd2;
        cycle();
        clear_in();
        #2;
        rst = 0;
        #1;
        model_reset();
        check_all();
        check("async_rst_pc", ifu_a.pc, RV);
        @(negedge clk);
        rst = 1;
        #1;
        check_all();
        cycle();
        check("reboot_valid", {31'd0, ifu_a.pc_valid}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ready   = ($urandom % 4) != 0;
            trap_en = ($urandom % 20) == 0;
            mret_en = ($urandom % 14) == 0;
            jalr_en = ($urandom % 10) == 0;
            jal_en  = ($urandom % 10) == 0;
            br_en   = ($urandom % 8) == 0;
            src_pc  = $urandom;
            imm     = $urandom_range(0, 127) - 64;
            rs1     = $urandom;
            mtvec   = $urandom & 32'hFFFF_FFFC;
            mepc    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
